// File: rtl/timing_pulse_sequencer_if.sv
// rtl/timing_pulse_sequencer_if.sv - control and pulse-train signal bundle for the timing pulse sequencer
interface timing_pulse_sequencer_if #(
  parameter int NUM_PULSES = 12,
  parameter int CNT_WIDTH  = 16
);
  localparam int PHASE_W = $clog2(NUM_PULSES);

  logic                  enable;
  logic                  step_mode;
  logic                  step;
  logic                  stall;
  logic [NUM_PULSES-1:0] tp;
  logic [PHASE_W-1:0]    phase;
  logic                  mct_done;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  mct_count;

  modport master (
    output enable, step_mode, step, stall,
    input  tp, phase, mct_done, busy, mct_count
  );

  modport slave (
    input  enable, step_mode, step, stall,
    output tp, phase, mct_done, busy, mct_count
  );
endinterface

// File: rtl/timing_pulse_sequencer.sv
// rtl/timing_pulse_sequencer.sv - one-hot timing pulse train per memory cycle time with run/step/stall control
module timing_pulse_sequencer #(
  parameter int NUM_PULSES     = 12,
  parameter int CLKS_PER_PULSE = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  timing_pulse_sequencer_if.slave       bus
);
  localparam int PHASE_W = $clog2(NUM_PULSES);
  localparam int DWELL_W = (CLKS_PER_PULSE > 1) ? $clog2(CLKS_PER_PULSE) : 1;
  localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(CLKS_PER_PULSE - 1);
  localparam logic [PHASE_W-1:0]    PHASE_LAST = PHASE_W'(NUM_PULSES - 1);
  localparam logic [NUM_PULSES-1:0] TP_FIRST   = NUM_PULSES'(1);

  typedef enum logic [1:0] {IDLE, RUN, RUN_ONE} state_t;

  state_t                state_q, state_n;
  logic [NUM_PULSES-1:0] tp_q, tp_n;
  logic [PHASE_W-1:0]    phase_q, phase_n;
  logic [DWELL_W-1:0]    dwell_q, dwell_n;
  logic                  done_q, done_n;
  logic                  busy_q, busy_n;
  logic [CNT_WIDTH-1:0]  count_q, count_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tp_q    <= '0;
      phase_q <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      tp_q    <= tp_n;
      phase_q <= phase_n;
      dwell_q <= dwell_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      count_q <= count_n;
    end
  end

  always_comb begin
    state_n = state_q;
    tp_n    = tp_q;
    phase_n = phase_q;
    dwell_n = dwell_q;
    done_n  = 1'b0;
    count_n = count_q;
    case (state_q)
      IDLE: begin
        tp_n    = '0;
        phase_n = '0;
        dwell_n = '0;
        if (bus.enable && !bus.step_mode) begin
          state_n = RUN;
          tp_n    = TP_FIRST;
        end else if (bus.step_mode && bus.step) begin
          state_n = RUN_ONE;
          tp_n    = TP_FIRST;
        end
      end
      RUN, RUN_ONE: begin
        // step is deliberately not looked at here: a request during an MCT is dropped
        if (!bus.stall) begin
          if (dwell_q != DWELL_LAST) begin
            dwell_n = dwell_q + DWELL_W'(1);
          end else if (phase_q != PHASE_LAST) begin
            dwell_n = '0;
            phase_n = phase_q + PHASE_W'(1);
            tp_n    = tp_q << 1;
          end else begin
            done_n  = 1'b1;
            count_n = count_q + CNT_WIDTH'(1);
            dwell_n = '0;
            phase_n = '0;
            if (state_q == RUN && bus.enable && !bus.step_mode) begin
              tp_n = TP_FIRST;
            end else begin
              state_n = IDLE;
              tp_n    = '0;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        tp_n    = '0;
        phase_n = '0;
        dwell_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  assign bus.tp        = tp_q;
  assign bus.phase     = phase_q;
  assign bus.mct_done  = done_q;
  assign bus.busy      = busy_q;
  assign bus.mct_count = count_q;
endmodule

// File: tb/tb_timing_pulse_sequencer.sv
// tb/tb_timing_pulse_sequencer.sv - bench for timing_pulse_sequencer with a position-in-MCT reference model
module tb_timing_pulse_sequencer;
  logic clk;
  logic reset;
  logic enable;
  logic step_mode;
  logic step;
  logic stall;

  int vectors;
  int miscompares;
  bit armed;

  timing_pulse_sequencer_if #(.NUM_PULSES(12), .CNT_WIDTH(16)) i0 ();
  timing_pulse_sequencer_if #(.NUM_PULSES(4),  .CNT_WIDTH(4))  i1 ();

  assign i0.enable    = enable;
  assign i0.step_mode = step_mode;
  assign i0.step      = step;
  assign i0.stall     = stall;
  assign i1.enable    = enable;
  assign i1.step_mode = step_mode;
  assign i1.step      = step;
  assign i1.stall     = stall;

  timing_pulse_sequencer #(.NUM_PULSES(12), .CLKS_PER_PULSE(1), .CNT_WIDTH(16)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (i0)
  );

  timing_pulse_sequencer #(.NUM_PULSES(4), .CLKS_PER_PULSE(3), .CNT_WIDTH(4)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an MCT is just a clock position 0..N*C-1; the pulse index is pos / C
  typedef struct packed {
    logic        run;
    logic        one;
    logic [31:0] pos;
    logic        done;
    logic [31:0] cnt;
  } model_t;

  model_t m0 = '0;
  model_t m1 = '0;

  function automatic model_t next_model(model_t m, int n, int c, logic [31:0] mask);
    model_t r;
    r      = m;
    r.done = 1'b0;
    if (reset) begin
      r = '0;
    end else if (!m.run) begin
      if (enable && !step_mode) begin
        r.run = 1'b1; r.one = 1'b0; r.pos = 0;
      end else if (step_mode && step) begin
        r.run = 1'b1; r.one = 1'b1; r.pos = 0;
      end
    end else if (!stall) begin
      if (m.pos == 32'(n * c - 1)) begin
        r.done = 1'b1;
        r.cnt  = (m.cnt + 1) & mask;
        r.pos  = 0;
        if (m.one || !enable || step_mode) r.run = 1'b0;
      end else begin
        r.pos = m.pos + 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m0 <= next_model(m0, 12, 1, 32'hFFFF);
    m1 <= next_model(m1, 4, 3, 32'hF);
    if (reset) armed <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag, input model_t m, input int c,
                           input logic [31:0] tp, input logic [31:0] ph, input logic done,
                           input logic busy, input logic [31:0] cnt);
    logic [31:0] etp;
    logic [31:0] eph;
    eph = m.run ? (m.pos / c) : 32'd0;
    etp = m.run ? (32'd1 << eph) : 32'd0;
    check({tag, ".tp"},        tp,   etp);
    check({tag, ".phase"},     ph,   eph);
    check({tag, ".mct_done"},  {31'd0, done}, {31'd0, m.done});
    check({tag, ".busy"},      {31'd0, busy}, {31'd0, m.run});
    check({tag, ".mct_count"}, cnt,  m.cnt);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_model("d0", m0, 1, 32'(i0.tp), 32'(i0.phase), i0.mct_done, i0.busy, 32'(i0.mct_count));
      cmp_model("d1", m1, 3, 32'(i1.tp), 32'(i1.phase), i1.mct_done, i1.busy, 32'(i1.mct_count));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; enable = 1'b0; step_mode = 1'b0; step = 1'b0; stall = 1'b0;
    tick(2);
    check("rst_tp",    32'(i0.tp), 32'h0);
    check("rst_busy",  32'(i0.busy), 32'h0);
    check("rst_count", 32'(i0.mct_count), 32'h0);
    check("rst_done",  32'(i0.mct_done), 32'h0);

    // Free run: tp walks one bit per clock, d1 holds each bit three clocks
    reset = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check("walk_tp0", 32'(i0.tp), 32'd1 << (k - 1));
      check("walk_tp1", 32'(i1.tp), 32'd1 << ((k - 1) / 3));
    end
    tick(1);
    check("mct1_tp",    32'(i0.tp), 32'h001);
    check("mct1_done",  32'(i0.mct_done), 32'h1);
    check("mct1_count", 32'(i0.mct_count), 32'h1);
    check("mct1_done1", 32'(i1.mct_done), 32'h1);
    tick(48);
    check("mct5_count",  32'(i0.mct_count), 32'd5);
    check("mct5_done",   32'(i0.mct_done), 32'h1);
    check("mct5_count1", 32'(i1.mct_count), 32'd5);

    // Drop enable mid-MCT: the MCT still completes
    tick(5);
    check("drop_phase", 32'(i0.phase), 32'd5);
    enable = 1'b0;
    tick(6);
    check("drop_tp11", 32'(i0.tp), 32'h800);
    tick(1);
    check("drop_tp",    32'(i0.tp), 32'h0);
    check("drop_busy",  32'(i0.busy), 32'h0);
    check("drop_done",  32'(i0.mct_done), 32'h1);
    check("drop_count", 32'(i0.mct_count), 32'd6);

    // Single step; second step mid-MCT must be ignored
    step_mode = 1'b1; step = 1'b1;
    tick(1);
    check("step_tp", 32'(i0.tp), 32'h001);
    step = 1'b0;
    tick(4);
    check("step_phase", 32'(i0.phase), 32'd4);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(7);
    check("step_end_done",  32'(i0.mct_done), 32'h1);
    check("step_end_busy",  32'(i0.busy), 32'h0);
    check("step_end_count", 32'(i0.mct_count), 32'd7);
    tick(2);
    check("step_idle_busy",  32'(i0.busy), 32'h0);
    check("step_idle_count", 32'(i0.mct_count), 32'd7);

    // Stall four clocks at phase 7: the MCT stretches to 16 clocks
    step_mode = 1'b0; enable = 1'b1;
    tick(8);
    check("stall_pre_tp", 32'(i0.tp), 32'h080);
    stall = 1'b1;
    tick(4);
    check("stall_tp",   32'(i0.tp), 32'h080);
    check("stall_done", 32'(i0.mct_done), 32'h0);
    stall = 1'b0;
    tick(4);
    check("stall_tp11",  32'(i0.tp), 32'h800);
    check("stall_done0", 32'(i0.mct_done), 32'h0);
    tick(1);
    check("stall_done1", 32'(i0.mct_done), 32'h1);
    check("stall_count", 32'(i0.mct_count), 32'd8);

    // Reset mid-run at phase 9, then restart
    tick(9);
    check("mid_phase", 32'(i0.phase), 32'd9);
    reset = 1'b1;
    tick(1);
    check("mid_rst_tp",    32'(i0.tp), 32'h0);
    check("mid_rst_phase", 32'(i0.phase), 32'h0);
    check("mid_rst_count", 32'(i0.mct_count), 32'h0);
    check("mid_rst_busy",  32'(i0.busy), 32'h0);
    reset = 1'b0;
    tick(1);
    check("restart_tp",   32'(i0.tp), 32'h001);
    check("restart_busy", 32'(i0.busy), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      step_mode = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 2) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timing_pulse_sequencer.md
Name: timing_pulse_sequencer

Overview:
Parametrised successor to the fixed 8-output timing-pulse generator. Produces a one-hot train of NUM_PULSES timing pulses per memory cycle time (MCT), each CLKS_PER_PULSE clocks wide. Supports free-run, single-MCT step, and stall modes, and reports MCT completion and a cycle count. Feeds the control-pulse decoder and the memory timing logic.

Parameters:
NUM_PULSES, 12, pulses per MCT (>=2); PHASE_W = $clog2(NUM_PULSES) is a derived localparam
CLKS_PER_PULSE, 1, clocks each pulse is held (>=1)
CNT_WIDTH, 16, width of the MCT counter

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
enable  in  1  free-run request
step_mode  in  1  1 = single-MCT step mode
step  in  1  in step mode, starts exactly one MCT
stall  in  1  freezes sequencing (holds current pulse)
tp  out  NUM_PULSES  one-hot timing pulses, tp[0] = first pulse
phase  out  PHASE_W  index of the active pulse
mct_done  out  1  one-cycle strobe at MCT completion
busy  out  1  high in RUN or RUN_ONE
mct_count  out  CNT_WIDTH  completed MCTs, wraps modulo 2^CNT_WIDTH

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, named reset. All outputs are registered.
- Reset, including mid-operation: takes effect at the next edge. Then state=IDLE, tp=0, phase=0, mct_done=0, busy=0, mct_count=0, dwell=0.
- Internal dwell counter runs 0..CLKS_PER_PULSE-1.
- IDLE:
  - tp=0, busy=0.
  - enable=1 and step_mode=0 -> RUN.
  - step_mode=1 and step=1 -> RUN_ONE.
  - stall is ignored.
- Entry latency: the edge that samples the start condition also sets tp=1<<0, phase=0, dwell=0, busy=1.
- RUN / RUN_ONE, each edge:
  - stall=1: tp, phase and dwell hold. No advance. mct_done=0.
  - stall=0 and dwell<CLKS_PER_PULSE-1: dwell+1.
  - stall=0 and dwell==CLKS_PER_PULSE-1 and phase<NUM_PULSES-1: dwell=0, phase+1, tp shifts left by one.
  - stall=0 and dwell==CLKS_PER_PULSE-1 and phase==NUM_PULSES-1: the MCT ends.
    - mct_done=1 for exactly this next cycle. mct_count+1, wrapping.
    - Continue condition: state is RUN, enable=1 and step_mode=0. If it holds, stay in RUN with phase=0, tp=1<<0, dwell=0.
    - Otherwise go to IDLE with tp=0, busy=0, phase=0.
- An MCT is never truncated.
  - Dropping enable mid-MCT, or setting step_mode mid-MCT, takes effect only at MCT end.
  - step asserted during RUN or RUN_ONE is ignored, not queued.
- mct_done is 0 in every cycle other than the one after MCT end.
- tp is always all-zero (IDLE) or exactly one-hot. phase always equals the index of the set bit, or 0 in IDLE.
- Period: with no stall, one MCT = NUM_PULSES*CLKS_PER_PULSE clocks. Back-to-back MCTs in RUN have no gap.
- Reset wins over every other input in the same cycle.

Test Plan:
- Reset, then enable=1, defaults (12,1): tp walks 0x001..0x800 on consecutive cycles. The 13th cycle shows tp=0x001 with mct_done=1 and mct_count=1. Continuous run over 5 MCTs gives mct_count=5 with no gap cycles.
- CLKS_PER_PULSE=3, NUM_PULSES=4, enable=1: each tp bit is held for exactly 3 clocks. mct_done fires every 12 clocks.
- Defaults, enable dropped while phase=5: sequence continues to tp[11]. Next cycle: tp=0, busy=0, mct_done=1.
- step_mode=1, step pulsed once: exactly one 12-pulse MCT, then IDLE. A second step pulsed at phase 4 is ignored. mct_count ends at 1.
- stall held 4 cycles at phase=7: tp=0x080 stays for 4 extra cycles. Total MCT = 16 clocks. mct_done fires only once.
- reset asserted at phase 9 in RUN: the next cycle shows tp=0, phase=0, mct_count=0, busy=0. A subsequent enable restarts at tp[0].
